// File: rtl/conv_window_sched.sv
// ---------------------------------------------------------------------------
// conv_window_sched
//
// Purpose:
//   Sequences a 3x3 elementwise multiply/accumulate datapath over a raster
//   frame of IMG_W x IMG_H 8-bit pixels. Two line buffers hold the previous
//   two image lines, and a 3x3 shift window is formed from them plus the
//   incoming pixel. For every position where a full window exists, the
//   window and the stored kernel are presented to the external datapath.
//   The 8-bit sum it returns is captured and offered downstream on a
//   valid/ready result port.
//
// Parameters:
//   IMG_W  frame width in pixels (>= 3)
//   IMG_H  frame height in lines (>= 3)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_k_load       load kernel from i_k_data (IDLE only)
//   i_k_data[72]   kernel {k00,k01,k02,k10,..,k22}, k00 in the MSBs
//   i_start        begin a frame (IDLE only)
//   o_busy         high while a frame is running or flushing
//   o_done         one-cycle pulse at the end of a frame
//   i_pix_valid    pixel offered
//   i_pix_data[8]  pixel, raster order
//   o_pix_ready    pixel accepted when i_pix_valid & o_pix_ready
//   o_mac_a[72]    window {w00..w22}; row 0 = oldest line, col 0 = oldest col
//   o_mac_b[72]    stored kernel
//   i_mac_sum[8]   datapath sum, combinational from o_mac_a/o_mac_b
//   o_res_valid    result held
//   o_res_data[8]  captured datapath sum
//   i_res_ready    result consumed when o_res_valid & i_res_ready
//
// Optional feature (macro DETECT_CNT_EN):
//   i_thresh[8]      detection threshold
//   o_obj_count[16]  number of results >= i_thresh in the current frame;
//                    cleared on start, stable from done until next start
// ---------------------------------------------------------------------------
module conv_window_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_k_load,
  input  logic [71:0] i_k_data,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_pix_data,
  output logic        o_pix_ready,
  output logic [71:0] o_mac_a,
  output logic [71:0] o_mac_b,
  input  logic [7:0]  i_mac_sum,
  output logic        o_res_valid,
  output logic [7:0]  o_res_data,
  input  logic        i_res_ready
`ifdef DETECT_CNT_EN
  ,
  input  logic [7:0]  i_thresh,
  output logic [15:0] o_obj_count
`endif
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic [7:0]       r_line_old [IMG_W];
  logic [7:0]       r_line_new [IMG_W];
  logic [7:0]       r_win [3][3];

  logic [71:0]      r_kernel;
  logic             r_win_pend;
  logic             r_res_valid;
  logic [7:0]       r_res_data;

  logic             w_pix_ready;
  logic             w_accept;
  logic             w_last_pix;
  logic             w_win_complete;
  logic             w_frame_start;
  logic             w_kernel_load;
  logic             w_res_fire;
  logic [71:0]      w_mac_a;

  // Control qualifiers. Start and kernel load are only meaningful in IDLE,
  // so they are masked here once and everything downstream can use them
  // without re-checking the state.
  assign w_frame_start = (r_state == S_IDLE) & i_start;
  assign w_kernel_load = (r_state == S_IDLE) & i_k_load;

  // A pixel can be taken only while running, only when no window is
  // waiting to be captured, and only if the result slot is free or being
  // emptied this very cycle. Holding off while a window is pending keeps
  // the window registers stable for the cycle the datapath sum is sampled.
  assign w_pix_ready    = (r_state == S_RUN) & ~r_win_pend & (~r_res_valid | i_res_ready);
  assign w_accept       = i_pix_valid & w_pix_ready;
  assign w_last_pix     = (r_row == LAST_ROW) & (r_col == LAST_COL);
  assign w_win_complete = w_accept & (r_row >= ROW_W'(2)) & (r_col >= COL_W'(2));
  assign w_res_fire     = r_res_valid & i_res_ready;

  assign o_pix_ready = w_pix_ready;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_mac_b     = r_kernel;
  assign o_mac_a     = w_mac_a;

  // State register for the frame sequencer. Reset drops any frame in
  // progress straight back to IDLE without passing through DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status decode. FLUSH exists because the last pixel
  // always completes a window, so the frame is not over until that final
  // result has been handed downstream.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_accept && w_last_pix) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        o_busy = 1'b1;
        if (!r_win_pend && !r_res_valid) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Raster position of the next pixel to be accepted. The row wraps with
  // the last pixel as well, but counters are also cleared on start so a
  // frame aborted by reset or otherwise can never leave a stale position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        if (r_row == LAST_ROW) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Two column-indexed line buffers. At each accepted pixel the entry for
  // this column ages from the newer line into the older one and the new
  // pixel takes its place. Contents are deliberately left uninitialised:
  // a window is only ever flagged once two full lines of the current
  // frame have passed through, so old data can never reach a result.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_line_old[r_col] <= r_line_new[r_col];
      r_line_new[r_col] <= i_pix_data;
    end
  end

  // The 3x3 window shifts one column left per accepted pixel; the new
  // right-hand column is the pixel two lines up, the pixel one line up,
  // and the incoming pixel, read from the buffers before they update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
      end
      r_win[0][2] <= r_line_old[r_col];
      r_win[1][2] <= r_line_new[r_col];
      r_win[2][2] <= i_pix_data;
    end
  end

  // Flatten the window onto the datapath bus with w00 in the top byte so
  // it lines up byte-for-byte with the kernel layout.
  always_comb begin
    w_mac_a = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_mac_a[71 - 8*(3*i + j) -: 8] = r_win[i][j];
      end
    end
  end

  // Kernel store. Loading in the same IDLE cycle as start is fine: the
  // first window cannot reach the datapath until several pixels later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kernel <= '0;
    end else if (w_kernel_load) begin
      r_kernel <= i_k_data;
    end
  end

  // Result capture. A completed window raises win_pend for exactly one
  // cycle, during which the datapath sum of the now-stable window is
  // sampled into the result register. Pixel acceptance guarantees the
  // result slot is empty by then, so capture never overwrites a result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_pend  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_win_pend <= w_win_complete;
      if (r_win_pend) begin
        r_res_valid <= 1'b1;
        r_res_data  <= i_mac_sum;
      end else if (w_res_fire) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef DETECT_CNT_EN
  logic [15:0] r_obj_count;

  // Detection counter: counts handed-off results at or above threshold.
  // Handshakes only occur while a frame is active, so the value freezes
  // on its own from done until the next start clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_obj_count <= '0;
    end else if (w_frame_start) begin
      r_obj_count <= '0;
    end else if (w_res_fire && (r_res_data >= i_thresh)) begin
      r_obj_count <= r_obj_count + 16'd1;
    end
  end

  assign o_obj_count = r_obj_count;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sched
//
// Self-checking bench for conv_window_sched (8x8 frame). The bench models
// the external datapath as a plain sum of byte products, builds a reference
// list of expected window sums straight from the frame image and kernel,
// and streams frames through the DUT with randomised valid/ready timing.
// Also covers the DETECT_CNT_EN object counter when that macro is defined.
// ---------------------------------------------------------------------------
module tb_conv_window_sched;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);
  localparam int THRESH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        kLoad;
  logic [71:0] kData;
  logic        start;
  logic        busy;
  logic        done;
  logic        pixValid;
  logic [7:0]  pixData;
  logic        pixReady;
  logic [71:0] macA;
  logic [71:0] macB;
  logic [7:0]  macSum;
  logic        resValid;
  logic [7:0]  resData;
  logic        resReady;
`ifdef DETECT_CNT_EN
  logic [7:0]  thresh;
  logic [15:0] objCount;
`endif

  int checks = 0;
  int errors = 0;
  int frame [NPIX];
  int kern [9];
  int expRes [NRES];
  int macAcc;

  conv_window_sched #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_k_load    (kLoad),
    .i_k_data    (kData),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .i_pix_valid (pixValid),
    .i_pix_data  (pixData),
    .o_pix_ready (pixReady),
    .o_mac_a     (macA),
    .o_mac_b     (macB),
    .i_mac_sum   (macSum),
    .o_res_valid (resValid),
    .o_res_data  (resData),
    .i_res_ready (resReady)
`ifdef DETECT_CNT_EN
    ,
    .i_thresh    (thresh),
    .o_obj_count (objCount)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the external multiply/accumulate datapath: nine byte
  // products summed, truncated to 8 bits.
  always_comb begin
    macAcc = 0;
    for (int i = 0; i < 9; i++) begin
      macAcc = macAcc + int'(macA[71 - 8*i -: 8]) * int'(macB[71 - 8*i -: 8]);
    end
    macSum = macAcc[7:0];
  end

  // Safety net in case a wait somewhere escapes its bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [71:0] packKernel();
    logic [71:0] k;
    k = '0;
    for (int i = 0; i < 9; i++) begin
      k[71 - 8*i -: 8] = 8'(kern[i]);
    end
    return k;
  endfunction

  // Frame and kernel contents for each scenario.
  task automatic fillFrame(input int pattern);
    for (int i = 0; i < NPIX; i++) begin
      case (pattern)
        0:       frame[i] = 1;
        1:       frame[i] = ((i / IMG_W) % 3 == 0) ? 5 : (((i / IMG_W) % 3 == 1) ? 2 : 1);
        2:       frame[i] = 6;
        3:       frame[i] = 16;
        5:       frame[i] = i % 256;
        default: frame[i] = int'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < 9; i++) begin
      case (pattern)
        0, 5:    kern[i] = 1;
        1:       kern[i] = (i < 3) ? 5 : ((i < 6) ? 2 : 1);
        2:       kern[i] = 6;
        3:       kern[i] = 16;
        default: kern[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Reference: every full 3x3 neighbourhood in raster order of its
  // bottom-right pixel, dot product with the kernel, modulo 256.
  task automatic buildExpected();
    int n;
    int s;
    n = 0;
    for (int r = 2; r < IMG_H; r++) begin
      for (int c = 2; c < IMG_W; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            s = s + frame[(r - 2 + i) * IMG_W + (c - 2 + j)] * kern[3*i + j];
          end
        end
        expRes[n] = s % 256;
        n++;
      end
    end
  endtask

  // Runs one frame. randMode randomises valid/ready and inserts a 10-cycle
  // res_ready stall; abortAt > 0 resets the DUT after that many pixels.
  task automatic applyStimulus(input int pattern, input bit randMode, input int abortAt);
    int pixIdx;
    int resIdx;
    int cyc;
    int lastAcc;
    int stallLeft;
    int modelCnt;
    bit doneSeen;
    bit stalled;
    bit holdPrev;
    logic [7:0] heldData;

    fillFrame(pattern);
    buildExpected();
    $display("[TB] frame pattern %0d rand %0d abort %0d", pattern, randMode, abortAt);

    @(negedge clk);
    kLoad = 1'b1;
    kData = packKernel();
    start = 1'b1;
    @(negedge clk);
    kLoad = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("macB", macB, packKernel());
    checkOutput("busyRun", 72'(busy), 72'(1));
`ifdef DETECT_CNT_EN
    checkOutput("objClear", 72'(objCount), 72'(0));
`endif

    pixIdx = 0; resIdx = 0; cyc = 0; lastAcc = -100;
    stallLeft = 0; modelCnt = 0; doneSeen = 0; stalled = 0;
    holdPrev = 0; heldData = '0;

    while (!doneSeen && cyc < 4000 && !(abortAt > 0 && pixIdx >= abortAt)) begin
      pixValid = (pixIdx < NPIX) && (!randMode || $urandom_range(0, 3) != 0);
      pixData  = (pixIdx < NPIX) ? 8'(frame[pixIdx]) : 8'($urandom_range(0, 255));
      if (randMode && !stalled && resIdx == 5) begin
        stalled   = 1;
        stallLeft = 10;
      end
      if (stallLeft > 0) begin
        resReady = 1'b0;
        stallLeft--;
      end else begin
        resReady = !randMode || $urandom_range(0, 2) != 0;
      end
      if (cyc == 10) begin
        kLoad = 1'b1;
        start = 1'b1;
        kData = ~packKernel();
      end else begin
        kLoad = 1'b0;
        start = 1'b0;
      end
      #1;

      if (resValid && !holdPrev) checkOutput("latency", 72'(cyc - lastAcc), 72'(2));
      if (resValid && holdPrev) checkOutput("resHold", 72'(resData), 72'(heldData));
      if (resValid && !resReady) checkOutput("stallPixReady", 72'(pixReady), 72'(0));
      if (done) begin
        doneSeen = 1;
        checkOutput("doneAfterAll", 72'(resIdx), 72'(NRES));
`ifdef DETECT_CNT_EN
        checkOutput("objCount", 72'(objCount), 72'(modelCnt));
`endif
      end

      if (resValid && resReady) begin
        if (resIdx < NRES) begin
          checkOutput($sformatf("res%0d", resIdx), 72'(resData), 72'(expRes[resIdx]));
          if (int'(resData) >= THRESH) modelCnt++;
        end else begin
          checkOutput("extraResult", 72'(resIdx), 72'(NRES - 1));
        end
        resIdx++;
      end
      holdPrev = resValid && !resReady;
      heldData = resData;

      if (pixValid && pixReady) begin
        if ((pixIdx / IMG_W) >= 2 && (pixIdx % IMG_W) >= 2) lastAcc = cyc;
        pixIdx++;
      end
      cyc++;
      @(negedge clk);
    end

    kLoad    = 1'b0;
    start    = 1'b0;
    pixValid = 1'b0;

    if (abortAt > 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abortBusy", 72'(busy), 72'(0));
      checkOutput("abortResValid", 72'(resValid), 72'(0));
      checkOutput("abortDone", 72'(done), 72'(0));
      checkOutput("abortMacA", macA, 72'(0));
    end else begin
      checkOutput("frameDone", 72'(doneSeen), 72'(1));
      checkOutput("resCount", 72'(resIdx), 72'(NRES));
      checkOutput("macBKept", macB, packKernel());
      pixValid = 1'b1;
      #1;
      checkOutput("donePulse", 72'(done), 72'(0));
      checkOutput("idleBusy", 72'(busy), 72'(0));
      checkOutput("idlePixReady", 72'(pixReady), 72'(0));
`ifdef DETECT_CNT_EN
      checkOutput("objStable", 72'(objCount), 72'(modelCnt));
`endif
      @(negedge clk);
      pixValid = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    kLoad    = 1'b0;
    kData    = '0;
    start    = 1'b0;
    pixValid = 1'b0;
    pixData  = '0;
    resReady = 1'b0;
`ifdef DETECT_CNT_EN
    thresh   = 8'(THRESH);
`endif
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstBusy", 72'(busy), 72'(0));
    checkOutput("rstDone", 72'(done), 72'(0));
    checkOutput("rstPixReady", 72'(pixReady), 72'(0));
    checkOutput("rstResValid", 72'(resValid), 72'(0));
    checkOutput("rstResData", 72'(resData), 72'(0));
    checkOutput("rstMacA", macA, 72'(0));
    checkOutput("rstMacB", macB, 72'(0));
`ifdef DETECT_CNT_EN
    checkOutput("rstObjCount", 72'(objCount), 72'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 1'b0, 0);
    applyStimulus(1, 1'b0, 0);
    applyStimulus(2, 1'b0, 0);
    applyStimulus(3, 1'b0, 0);
    applyStimulus(4, 1'b1, 0);
    applyStimulus(4, 1'b1, 20);
    applyStimulus(4, 1'b1, 0);
    applyStimulus(5, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
